// File: rtl/irrigation_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_pkg
// Description : Shared types for the irrigation actuator path: controller
//               state encoding, result codes and the default time width.
// Revision    : 1.0 - initial release
// ============================================================================
package irrigation_pkg;

    localparam int TIME_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATER    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_DONE  = 2'd1,
        RES_RAIN  = 2'd2,
        RES_ABORT = 2'd3
    } result_t;

endpackage : irrigation_pkg
`default_nettype wire

// File: rtl/irrigation_valve_ctrl_unit_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : unit_tick_gen
// Description : Time-unit prescaler. Counts clk cycles and flags the last
//               cycle of each unit; a clear restarts the unit from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module unit_tick_gen #(
    parameter int TICKS_PER_UNIT = 50000000,
    parameter int PRESCALE_WIDTH = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [PRESCALE_WIDTH-1:0] c_LAST = PRESCALE_WIDTH'(TICKS_PER_UNIT - 1);

    logic [PRESCALE_WIDTH-1:0] r_count;

    // Tick is a decode of the counter register, so it is glitch-free.
    assign o_tick = (r_count == c_LAST);

    // Free-running unit counter, wrapping on the tick and restarted on clear.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + PRESCALE_WIDTH'(1);
        end
    end

endmodule : unit_tick_gen
`default_nettype wire

// File: rtl/irrigation_valve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_valve_ctrl
// Description : Drives the pump/valve for a latched number of time units,
//               aborts on rain or manual stop, then holds a cooldown before
//               accepting another request. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module irrigation_valve_ctrl
    import irrigation_pkg::*;
#(
    parameter int TICKS_PER_UNIT = 50000000,
    parameter int PRESCALE_WIDTH = 26,
    parameter int TIME_WIDTH     = TIME_WIDTH_DEF,
    parameter int COOLDOWN_UNITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TIME_WIDTH-1:0] i_irrigation_time,
    input  logic                  i_rain_present,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic                  o_valve_on,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TIME_WIDTH-1:0] o_remaining,
    output logic [1:0]            o_last_result
);

    // Cooldown unit counter only needs to reach COOLDOWN_UNITS-1.
    localparam int c_CD_WIDTH = (COOLDOWN_UNITS > 1) ? $clog2(COOLDOWN_UNITS + 1) : 1;
    localparam logic [c_CD_WIDTH-1:0] c_CD_LAST =
        (COOLDOWN_UNITS > 0) ? c_CD_WIDTH'(COOLDOWN_UNITS - 1) : '0;

    state_t                  r_state;
    logic                    r_valve;
    logic                    r_done;
    logic [TIME_WIDTH-1:0]   r_remaining;
    result_t                 r_result;
    logic [c_CD_WIDTH-1:0]   r_cd_units;

    state_t                  w_state_nx;
    logic                    w_valve_nx;
    logic                    w_done_nx;
    logic [TIME_WIDTH-1:0]   w_remaining_nx;
    result_t                 w_result_nx;
    logic [c_CD_WIDTH-1:0]   w_cd_units_nx;
    logic                    w_presc_clr;
    logic                    w_tick;

    unit_tick_gen #(
        .TICKS_PER_UNIT (TICKS_PER_UNIT),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_presc_clr),
        .o_tick (w_tick)
    );

    // State and output registers; reset drops the valve on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_valve     <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_result    <= RES_NONE;
            r_cd_units  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_valve     <= w_valve_nx;
            r_done      <= w_done_nx;
            r_remaining <= w_remaining_nx;
            r_result    <= w_result_nx;
            r_cd_units  <= w_cd_units_nx;
        end
    end

    // Next-state and next-output logic; rain/abort outranks the unit tick.
    always_comb begin
        w_state_nx     = r_state;
        w_valve_nx     = r_valve;
        w_done_nx      = 1'b0;
        w_remaining_nx = r_remaining;
        w_result_nx    = r_result;
        w_cd_units_nx  = r_cd_units;
        w_presc_clr    = 1'b0;

        case (r_state)
            IDLE: begin
                w_valve_nx     = 1'b0;
                w_remaining_nx = '0;
                w_presc_clr    = 1'b1;
                if (i_start) begin
                    if (i_rain_present) begin
                        w_done_nx   = 1'b1;
                        w_result_nx = RES_RAIN;
                    end else if (i_irrigation_time == '0) begin
                        w_done_nx   = 1'b1;
                        w_result_nx = RES_DONE;
                    end else begin
                        w_state_nx     = WATER;
                        w_valve_nx     = 1'b1;
                        w_remaining_nx = i_irrigation_time;
                        w_result_nx    = RES_NONE;
                    end
                end
            end

            WATER: begin
                if (i_rain_present || i_abort || (w_tick && r_remaining == TIME_WIDTH'(1))) begin
                    w_valve_nx     = 1'b0;
                    w_remaining_nx = '0;
                    w_done_nx      = 1'b1;
                    if (i_rain_present) begin
                        w_result_nx = RES_RAIN;
                    end else if (i_abort) begin
                        w_result_nx = RES_ABORT;
                    end else begin
                        w_result_nx = RES_DONE;
                    end
                    w_presc_clr   = 1'b1;
                    w_cd_units_nx = '0;
                    w_state_nx    = (COOLDOWN_UNITS == 0) ? IDLE : COOLDOWN;
                end else if (w_tick) begin
                    w_remaining_nx = r_remaining - TIME_WIDTH'(1);
                end
            end

            COOLDOWN: begin
                if (w_tick) begin
                    if (r_cd_units == c_CD_LAST) begin
                        w_state_nx  = IDLE;
                        w_presc_clr = 1'b1;
                    end else begin
                        w_cd_units_nx = r_cd_units + c_CD_WIDTH'(1);
                    end
                end
            end

            default: begin
                w_state_nx     = IDLE;
                w_valve_nx     = 1'b0;
                w_remaining_nx = '0;
                w_presc_clr    = 1'b1;
            end
        endcase
    end

    assign o_valve_on    = r_valve;
    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_remaining   = r_remaining;
    assign o_last_result = r_result;

endmodule : irrigation_valve_ctrl
`default_nettype wire

// File: tb/tb_irrigation_valve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irrigation_valve_ctrl
// Description : Directed self-checking bench for irrigation_valve_ctrl with
//               TICKS_PER_UNIT=4 and COOLDOWN_UNITS=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irrigation_valve_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] i_irrigation_time;
    logic       i_rain_present;
    logic       i_start;
    logic       i_abort;
    logic       o_valve_on;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_remaining;
    logic [1:0] o_last_result;

    int pass_cnt;
    int total_cnt;

    irrigation_valve_ctrl #(
        .TICKS_PER_UNIT (4),
        .PRESCALE_WIDTH (4),
        .TIME_WIDTH     (8),
        .COOLDOWN_UNITS (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_irrigation_time (i_irrigation_time),
        .i_rain_present    (i_rain_present),
        .i_start           (i_start),
        .i_abort           (i_abort),
        .o_valve_on        (o_valve_on),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_remaining       (o_remaining),
        .o_last_result     (o_last_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge and settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({o_valve_on, o_busy, o_done, o_remaining, o_last_result} !== 13'd0) begin
            $display("FAIL reset_outputs got v=%0b b=%0b d=%0b r=%0d lr=%0d required all 0",
                     o_valve_on, o_busy, o_done, o_remaining, o_last_result);
        end else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_normal_run();
        int exp_rem;
        i_irrigation_time = 8'd3;
        i_start = 1'b1;
        tick();                                   // E0
        i_start = 1'b0;
        total_cnt++;
        if (o_valve_on !== 1'b1 || o_remaining !== 8'd3 || o_busy !== 1'b1 || o_last_result !== 2'd0 || o_done !== 1'b0) begin
            $display("FAIL run_e0 got v=%0b r=%0d b=%0b lr=%0d d=%0b required v=1 r=3 b=1 lr=0 d=0",
                     o_valve_on, o_remaining, o_busy, o_last_result, o_done);
        end else pass_cnt++;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_rem = (k < 12) ? 3 - k / 4 : 0;
            total_cnt++;
            if (o_valve_on !== (k < 12) || o_remaining !== 8'(exp_rem) || o_done !== (k == 12)) begin
                $display("FAIL run_e%0d got v=%0b r=%0d d=%0b required v=%0b r=%0d d=%0b",
                         k, o_valve_on, o_remaining, o_done, (k < 12), exp_rem, (k == 12));
            end else pass_cnt++;
        end
        total_cnt++;
        if (o_last_result !== 2'd1) begin
            $display("FAIL run_result got %0d required 1", o_last_result);
        end else pass_cnt++;
        for (int k = 13; k <= 20; k++) begin
            tick();
            total_cnt++;
            if (o_busy !== (k < 20) || o_done !== 1'b0) begin
                $display("FAIL run_cool_e%0d got b=%0b d=%0b required b=%0b d=0", k, o_busy, o_done, (k < 20));
            end else pass_cnt++;
        end
    endtask

    task automatic test_rain_abort();
        i_irrigation_time = 8'd5;
        i_start = 1'b1;
        tick();                                   // E0
        i_start = 1'b0;
        for (int k = 1; k <= 5; k++) tick();      // E5
        total_cnt++;
        if (o_valve_on !== 1'b1 || o_remaining !== 8'd4) begin
            $display("FAIL rain_pre got v=%0b r=%0d required v=1 r=4", o_valve_on, o_remaining);
        end else pass_cnt++;
        i_rain_present = 1'b1;
        tick();                                   // E6
        i_rain_present = 1'b0;
        total_cnt++;
        if (o_valve_on !== 1'b0 || o_remaining !== 8'd0 || o_done !== 1'b1 || o_last_result !== 2'd2 || o_busy !== 1'b1) begin
            $display("FAIL rain_edge got v=%0b r=%0d d=%0b lr=%0d b=%0b required v=0 r=0 d=1 lr=2 b=1",
                     o_valve_on, o_remaining, o_done, o_last_result, o_busy);
        end else pass_cnt++;
        for (int k = 7; k <= 14; k++) begin
            tick();
            total_cnt++;
            if (o_busy !== (k < 14) || o_done !== 1'b0) begin
                $display("FAIL rain_cool_e%0d got b=%0b d=%0b required b=%0b d=0", k, o_busy, o_done, (k < 14));
            end else pass_cnt++;
        end
    endtask

    task automatic test_rain_skip();
        i_irrigation_time = 8'd10;
        i_rain_present = 1'b1;
        i_start = 1'b1;
        for (int k = 0; k < 2; k++) begin         // held start: done each cycle
            tick();
            total_cnt++;
            if (o_done !== 1'b1 || o_last_result !== 2'd2 || o_valve_on !== 1'b0 || o_busy !== 1'b0) begin
                $display("FAIL skip_%0d got d=%0b lr=%0d v=%0b b=%0b required d=1 lr=2 v=0 b=0",
                         k, o_done, o_last_result, o_valve_on, o_busy);
            end else pass_cnt++;
        end
        i_start = 1'b0;
        tick();
        i_rain_present = 1'b0;
        total_cnt++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_last_result !== 2'd2) begin
            $display("FAIL skip_after got d=%0b b=%0b lr=%0d required d=0 b=0 lr=2", o_done, o_busy, o_last_result);
        end else pass_cnt++;
    endtask

    task automatic test_zero_and_both();
        i_irrigation_time = 8'd0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        total_cnt++;
        if (o_done !== 1'b1 || o_last_result !== 2'd1 || o_valve_on !== 1'b0 || o_busy !== 1'b0) begin
            $display("FAIL zero_time got d=%0b lr=%0d v=%0b b=%0b required d=1 lr=1 v=0 b=0",
                     o_done, o_last_result, o_valve_on, o_busy);
        end else pass_cnt++;
        i_irrigation_time = 8'd2;
        i_start = 1'b1;
        tick();                                   // E0
        i_start = 1'b0;
        i_abort = 1'b1;                           // abort in WATER alone -> 3 later case
        i_rain_present = 1'b1;
        tick();                                   // E1
        i_abort = 1'b0;
        i_rain_present = 1'b0;
        total_cnt++;
        if (o_last_result !== 2'd2 || o_valve_on !== 1'b0 || o_done !== 1'b1) begin
            $display("FAIL both_rain_abort got lr=%0d v=%0b d=%0b required lr=2 v=0 d=1",
                     o_last_result, o_valve_on, o_done);
        end else pass_cnt++;
        for (int k = 0; k < 8; k++) tick();
        total_cnt++;
        if (o_busy !== 1'b0) begin
            $display("FAIL both_cool got b=%0b required 0", o_busy);
        end else pass_cnt++;
        // Manual abort alone on the final-unit tick edge
        i_irrigation_time = 8'd1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick(); tick();                   // E3
        i_abort = 1'b1;
        tick();                                   // E4, terminal tick coincides
        i_abort = 1'b0;
        total_cnt++;
        if (o_last_result !== 2'd3 || o_valve_on !== 1'b0 || o_done !== 1'b1) begin
            $display("FAIL abort_terminal got lr=%0d v=%0b d=%0b required lr=3 v=0 d=1",
                     o_last_result, o_valve_on, o_done);
        end else pass_cnt++;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        i_irrigation_time = 8'd3;
        i_start = 1'b1;
        tick();                                   // E0
        i_start = 1'b0;
        i_irrigation_time = 8'd255;
        for (int k = 1; k <= 21; k++) begin
            i_start = (k == 5 || k == 10 || k == 16 || k == 19);
            tick();
            if (o_done) dones++;
            if (k == 11 || k == 12) begin
                total_cnt++;
                if (o_valve_on !== (k == 11)) begin
                    $display("FAIL b2b_valve_e%0d got %0b required %0b", k, o_valve_on, (k == 11));
                end else pass_cnt++;
            end
        end
        i_start = 1'b0;
        total_cnt++;
        if (dones !== 1 || o_busy !== 1'b0 || o_valve_on !== 1'b0 || o_last_result !== 2'd1) begin
            $display("FAIL b2b_end got dones=%0d b=%0b v=%0b lr=%0d required dones=1 b=0 v=0 lr=1",
                     dones, o_busy, o_valve_on, o_last_result);
        end else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        i_irrigation_time = 8'd3;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        reset = 1'b1;
        tick();                                   // E5
        reset = 1'b0;
        total_cnt++;
        if (o_valve_on !== 1'b0 || o_busy !== 1'b0 || o_remaining !== 8'd0 || o_last_result !== 2'd0) begin
            $display("FAIL mid_reset got v=%0b b=%0b r=%0d lr=%0d required all 0",
                     o_valve_on, o_busy, o_remaining, o_last_result);
        end else pass_cnt++;
        i_irrigation_time = 8'd1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        total_cnt++;
        if (o_valve_on !== 1'b1 || o_remaining !== 8'd1) begin
            $display("FAIL post_reset_start got v=%0b r=%0d required v=1 r=1", o_valve_on, o_remaining);
        end else pass_cnt++;
        for (int k = 1; k <= 4; k++) tick();
        total_cnt++;
        if (o_valve_on !== 1'b0 || o_done !== 1'b1 || o_last_result !== 2'd1) begin
            $display("FAIL post_reset_end got v=%0b d=%0b lr=%0d required v=0 d=1 lr=1",
                     o_valve_on, o_done, o_last_result);
        end else pass_cnt++;
    endtask

    initial begin
        pass_cnt          = 0;
        total_cnt         = 0;
        reset             = 1'b1;
        i_irrigation_time = 8'd0;
        i_rain_present    = 1'b0;
        i_start           = 1'b0;
        i_abort           = 1'b0;
        test_reset();
        test_normal_run();
        test_rain_abort();
        test_rain_skip();
        test_zero_and_both();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_irrigation_valve_ctrl
`default_nettype wire
